// File: rtl/toy_bus_dbg_initiator.sv
// toy_bus_dbg_initiator
//   Debug-side toy bus initiator. Takes single-beat read/write commands from
//   the local debug controller, issues them as ToyBusReq with this node's
//   source ID, and for reads waits for the matching ToyBusAck. One
//   transaction outstanding at a time; a timeout guard answers a read with
//   an error response if no matching ack arrives.
//
// Parameters
//   NODE_ID : this node's ID (net_req_src_id, ack target filter)
//   TO_W    : ack-timeout counter width (timeout after 2^TO_W-1 wait cycles)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_*                      local command channel (vld/rdy handshake)
//   rsp_*                      local response channel (vld/rdy handshake)
//   net_req_*                  network request channel (vld/rdy handshake)
//   net_ack_*                  network ack channel (always ready)
module toy_bus_dbg_initiator #(
   parameter logic [3:0]  NODE_ID = 4'd1,
   parameter int unsigned TO_W    = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_vld,
   output logic        cmd_rdy,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_data,
   input  logic [3:0]  cmd_strb,
   input  logic        cmd_opcode,
   input  logic [3:0]  cmd_tgt_id,
   output logic        rsp_vld,
   input  logic        rsp_rdy,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        rsp_opcode,
   output logic        net_req_vld,
   input  logic        net_req_rdy,
   output logic [31:0] net_req_addr,
   output logic [31:0] net_req_data,
   output logic [3:0]  net_req_strb,
   output logic        net_req_opcode,
   output logic [3:0]  net_req_src_id,
   output logic [3:0]  net_req_tgt_id,
   input  logic        net_ack_vld,
   output logic        net_ack_rdy,
   input  logic        net_ack_opcode,
   input  logic [31:0] net_ack_data,
   input  logic [3:0]  net_ack_src_id,
   input  logic [3:0]  net_ack_tgt_id
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_ACK,
      RESP
   } state_t;

   // Counter is cleared on the request handshake, so the last waiting cycle
   // sees all-ones minus one; the registered transition then lands RESP
   // exactly 2^TO_W cycles after the handshake.
   localparam logic [TO_W-1:0] CNT_LAST = {TO_W{1'b1}} - TO_W'(1);

   state_t          state;
   logic [31:0]     addr_q;
   logic [31:0]     data_q;
   logic [3:0]      strb_q;
   logic            op_q;
   logic [3:0]      tgt_q;
   logic [31:0]     rdata_q;
   logic            err_q;
   logic [TO_W-1:0] cnt;
   logic            cmd_rdy_q;
   logic            req_vld_q;
   logic            rsp_vld_q;
   logic            ack_match;

   // Ack opcode and source are not needed to match a response.
   logic unused_ack_fields;
   assign unused_ack_fields = ^{net_ack_opcode, net_ack_src_id};

   assign ack_match = net_ack_vld && (net_ack_tgt_id == NODE_ID);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         op_q      <= 1'b0;
         tgt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         cnt       <= '0;
         cmd_rdy_q <= 1'b1;
         req_vld_q <= 1'b0;
         rsp_vld_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_vld) begin
                  addr_q    <= cmd_addr;
                  data_q    <= cmd_data;
                  strb_q    <= cmd_strb;
                  op_q      <= cmd_opcode;
                  tgt_q     <= cmd_tgt_id;
                  rdata_q   <= '0;
                  err_q     <= 1'b0;
                  cmd_rdy_q <= 1'b0;
                  req_vld_q <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (net_req_rdy) begin
                  req_vld_q <= 1'b0;
                  cnt       <= '0;
                  if (op_q) begin
                     // Writes are not acked; the request handshake completes them.
                     rsp_vld_q <= 1'b1;
                     state     <= RESP;
                  end else begin
                     state <= WAIT_ACK;
                  end
               end
            end
            WAIT_ACK: begin
               // A matching ack takes priority over a coincident timeout.
               if (ack_match) begin
                  rdata_q   <= net_ack_data;
                  err_q     <= 1'b0;
                  rsp_vld_q <= 1'b1;
                  state     <= RESP;
               end else if (cnt == CNT_LAST) begin
                  rdata_q   <= '0;
                  err_q     <= 1'b1;
                  rsp_vld_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + TO_W'(1);
               end
            end
            RESP: begin
               if (rsp_rdy) begin
                  rsp_vld_q <= 1'b0;
                  cmd_rdy_q <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               cmd_rdy_q <= 1'b1;
               req_vld_q <= 1'b0;
               rsp_vld_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign cmd_rdy        = cmd_rdy_q;
   assign net_req_vld    = req_vld_q;
   assign net_req_addr   = addr_q;
   assign net_req_data   = data_q;
   assign net_req_strb   = strb_q;
   assign net_req_opcode = op_q;
   assign net_req_src_id = NODE_ID;
   assign net_req_tgt_id = tgt_q;
   assign net_ack_rdy    = 1'b1;
   assign rsp_vld        = rsp_vld_q;
   assign rsp_data       = rdata_q;
   assign rsp_err        = err_q;
   assign rsp_opcode     = op_q;

endmodule
